// File: rtl/ls161_mod_sequencer_if.sv
// Control/status bundle between the divide-by-M sequencer and its
// 74LS161-style counter plus downstream consumers.
interface ls161_mod_sequencer_if #(
  parameter int PRE_W = 8,
  parameter int WC_W  = 8
);
  logic             start;
  logic             stop;
  logic [3:0]       modulus;
  logic [PRE_W-1:0] prescale;
  logic             RCO;
  logic [3:0]       D;
  logic             LOAD_n;
  logic             ENP;
  logic             ENT;
  logic             tick;
  logic             busy;
  logic [WC_W-1:0]  wrap_count;

  modport master (
    input  start, stop, modulus, prescale, RCO,
    output D, LOAD_n, ENP, ENT, tick, busy, wrap_count
  );

  modport slave (
    output start, stop, modulus, prescale, RCO,
    input  D, LOAD_n, ENP, ENT, tick, busy, wrap_count
  );
endinterface

// File: rtl/ls161_mod_sequencer.sv
// Upstream control for a 4-bit LS161-style counter: programmable
// divide-by-M with an ENP prescaler, wrap tick and saturating count.
module ls161_mod_sequencer #(
  parameter int PRE_W = 8,
  parameter int WC_W  = 8
) (
  input  logic CLK,
  input  logic CLR_n,
  ls161_mod_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [WC_W-1:0] WC_MAX = '1;

  state_t           state_q;
  logic [3:0]       mod_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;
  logic             enp_q;
  logic             ent_q;
  logic             tick_q;
  logic [WC_W-1:0]  wc_q;
  logic             wrap;

  // An LS161 raises RCO from ENT alone, so while the prescaler holds
  // the count at 15 RCO stays high; only the ENP cycle is a real wrap.
  assign wrap = (state_q == RUN) && bus.RCO && enp_q;

  assign pcnt_d = (pcnt_q == pre_q) ? '0 : pcnt_q + 1'b1;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      mod_q   <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      enp_q   <= 1'b0;
      ent_q   <= 1'b0;
      tick_q  <= 1'b0;
      wc_q    <= '0;
    end else begin
      tick_q <= wrap;
      if (wrap && (wc_q != WC_MAX)) begin
        wc_q <= wc_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q <= LOAD;
            mod_q   <= bus.modulus;
            pre_q   <= bus.prescale;
            pcnt_q  <= '0;
            wc_q    <= '0;
          end
        end
        LOAD: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else begin
            state_q <= RUN;
            enp_q   <= 1'b1;
            ent_q   <= 1'b1;
            pcnt_q  <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            enp_q   <= 1'b0;
            ent_q   <= 1'b0;
          end else begin
            pcnt_q <= pcnt_d;
            enp_q  <= (pcnt_d == '0);
          end
        end
        default: begin
          state_q <= IDLE;
          enp_q   <= 1'b0;
          ent_q   <= 1'b0;
        end
      endcase
    end
  end

  // (16 - M) mod 16 falls out of 4-bit negation, including M=0 -> 0.
  assign bus.D          = 4'd0 - mod_q;
  assign bus.LOAD_n     = (state_q == LOAD) ? 1'b0 : ~wrap;
  assign bus.ENP        = enp_q;
  assign bus.ENT        = ent_q;
  assign bus.tick       = tick_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.wrap_count = wc_q;

endmodule
